jt900h_regbank: RTL and testbench

- Parametrised successor to the current register file for the jt900h CPU core.
- Holds NBANKS banked 16-byte register sets plus a 16-byte dedicated pointer set (XWA..XSP-style).
- Provides two combinational 32-bit read ports, one sized write port, and a registered bank pointer (rfp) with increment, decrement and load.
- Supports pointer post-increment and pre-decrement for the indexed memory addresser; sits between the instruction decoder/ALU and the memory addresser.

---
 rtl/jt900h_regbank_if.sv | 36 +++
 rtl/jt900h_regbank.sv | 131 +++++++++++++
 tb/tb_jt900h_regbank.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/jt900h_regbank_if.sv
// Bus between the jt900h decoder/ALU/addresser and the register bank.
// Carries read selectors/data, pointer step controls, write port and rfp controls.
// Master drives selectors and strobes; slave (the regbank) returns reads, addr_out and rfp.
interface jt900h_regbank_if;
  logic        cen;
  logic [7:0]  rd0_sel;
  logic [7:0]  rd1_sel;
  logic [1:0]  rd_z;
  logic [31:0] rd0_out;
  logic [31:0] rd1_out;
  logic [1:0]  step_z;
  logic        ptr_inc;
  logic        ptr_dec;
  logic [31:0] addr_out;
  logic [7:0]  wr_sel;
  logic [1:0]  wr_z;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        rf_inc;
  logic        rf_dec;
  logic        rf_ld;
  logic [2:0]  rf_din;
  logic [2:0]  rfp;

  modport master (
    output cen, rd0_sel, rd1_sel, rd_z, step_z, ptr_inc, ptr_dec,
           wr_sel, wr_z, wr_en, wr_data, rf_inc, rf_dec, rf_ld, rf_din,
    input  rd0_out, rd1_out, addr_out, rfp
  );

  modport slave (
    input  cen, rd0_sel, rd1_sel, rd_z, step_z, ptr_inc, ptr_dec,
           wr_sel, wr_z, wr_en, wr_data, rf_inc, rf_dec, rf_ld, rf_din,
    output rd0_out, rd1_out, addr_out, rfp
  );
endinterface

// File: rtl/jt900h_regbank.sv
// Banked register file (NBANKS x 16 bytes + 16-byte pointer set) with bank pointer rfp.
// Latency: reads/addr_out combinational from stored state; writes visible one cen edge later.
// Backpressure: none; cen stalls every state update while reads stay live.
// Ports: clk, rst (sync, active-high), bus (slave modport of jt900h_regbank_if).
module jt900h_regbank #(
  parameter int          NBANKS  = 4,
  parameter logic [31:0] XSP_RST = 32'h0000_0100
) (
  input  logic             clk,
  input  logic             rst,
  jt900h_regbank_if.slave  bus
);
  localparam int BW = $clog2(NBANKS);
  localparam int SW = $clog2(NBANKS + 1);
  localparam int IW = SW + 2;
  localparam int NL = 4 * (NBANKS + 1);
  // Pointer set lives after the banks; its long 3 is the stack pointer.
  localparam int XSP_IDX = 4 * NBANKS + 3;

  logic [31:0]   regs_q [NL];
  logic [31:0]   regs_d [NL];
  logic [BW-1:0] rfp_q;
  logic [BW-1:0] rfp_d;

  // Long index = {register set, long within set}; sel[1:0] is not needed here.
  function automatic logic [IW-1:0] long_idx(input logic [7:2] sel, input logic [BW-1:0] rp);
    logic [BW-1:0] bank;
    logic [BW-1:0] rpm;
    logic [SW-1:0] set;
    bank = sel[BW+3:4];
    rpm  = rp - BW'(1);
    case (sel[7:4])
      4'hF:    set = SW'(NBANKS);
      4'hE:    set = SW'(rp);
      4'hD:    set = SW'(rpm);
      default: set = SW'(bank);
    endcase
    return {set, sel[3:2]};
  endfunction

  function automatic logic [31:0] size_sel(input logic [31:0] l, input logic [1:0] off,
                                           input logic [1:0] z);
    logic [31:0] sh;
    logic [31:0] res;
    case (z)
      2'd0: begin
        sh  = l >> {off, 3'b000};
        res = {24'd0, sh[7:0]};
      end
      2'd1: begin
        sh  = l >> {off[1], 4'b0000};
        res = {16'd0, sh[15:0]};
      end
      default: res = l;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] step_of(input logic [1:0] z);
    case (z)
      2'd1:    return 32'd2;
      2'd2:    return 32'd4;
      default: return 32'd1;
    endcase
  endfunction

  logic [IW-1:0] rd0_idx, rd1_idx, wr_idx;
  logic [31:0]   rd0_long, rd1_long, step, ptr_dec_val;
  logic [31:0]   wr_lane;
  logic [3:0]    wr_mask;

  assign rd0_idx     = long_idx(bus.rd0_sel[7:2], rfp_q);
  assign rd1_idx     = long_idx(bus.rd1_sel[7:2], rfp_q);
  assign wr_idx      = long_idx(bus.wr_sel[7:2], rfp_q);
  assign rd0_long    = regs_q[rd0_idx];
  assign rd1_long    = regs_q[rd1_idx];
  assign step        = step_of(bus.step_z);
  assign ptr_dec_val = rd0_long - step;

  assign bus.rd0_out  = size_sel(rd0_long, bus.rd0_sel[1:0], bus.rd_z);
  assign bus.rd1_out  = size_sel(rd1_long, bus.rd1_sel[1:0], bus.rd_z);
  assign bus.addr_out = bus.ptr_dec ? ptr_dec_val : rd0_long;
  assign bus.rfp      = 3'(rfp_q);

  // Replicate write data across lanes so the mask alone picks the target bytes.
  always_comb begin
    wr_lane = bus.wr_data;
    wr_mask = 4'hF;
    case (bus.wr_z)
      2'd0: begin
        wr_lane = {4{bus.wr_data[7:0]}};
        wr_mask = 4'b0001 << bus.wr_sel[1:0];
      end
      2'd1: begin
        wr_lane = {2{bus.wr_data[15:0]}};
        wr_mask = bus.wr_sel[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Pointer update first, then the write port overrides the bytes it covers.
  always_comb begin
    for (int i = 0; i < NL; i++) regs_d[i] = regs_q[i];
    if (bus.ptr_dec)
      regs_d[rd0_idx] = ptr_dec_val;
    else if (bus.ptr_inc)
      regs_d[rd0_idx] = rd0_long + step;
    if (bus.wr_en) begin
      for (int b = 0; b < 4; b++)
        if (wr_mask[b]) regs_d[wr_idx][b*8 +: 8] = wr_lane[b*8 +: 8];
    end
    rfp_d = rfp_q;
    if (bus.rf_ld)
      rfp_d = BW'(bus.rf_din);
    else if (bus.rf_inc)
      rfp_d = rfp_q + BW'(1);
    else if (bus.rf_dec)
      rfp_d = rfp_q - BW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NL; i++) regs_q[i] <= (i == XSP_IDX) ? XSP_RST : 32'd0;
      rfp_q <= '0;
    end else if (bus.cen) begin
      for (int i = 0; i < NL; i++) regs_q[i] <= regs_d[i];
      rfp_q <= rfp_d;
    end
  end
endmodule

// File: tb/tb_jt900h_regbank.sv
// Self-checking bench for jt900h_regbank: directed plan steps, then random traffic
// checked against a byte-array reference model of the register sets and rfp.
module tb_jt900h_regbank;
  localparam int          NB  = 4;
  localparam logic [31:0] XSP = 32'h0000_0100;

  logic clk;
  logic rst;
  int   nvec = 0;
  int   nerr = 0;

  jt900h_regbank_if bus ();

  jt900h_regbank #(.NBANKS(NB), .XSP_RST(XSP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: set NB is the pointer set, bytes stored little-endian.
  logic [7:0] m [0:NB][0:15];
  int         mrfp;

  function automatic int mset(input logic [7:0] sel);
    int hi;
    hi = int'(sel[7:4]);
    if (hi == 15) return NB;
    if (hi == 14) return mrfp;
    if (hi == 13) return (mrfp + NB - 1) % NB;
    return hi % NB;
  endfunction

  function automatic logic [31:0] mread(input logic [7:0] sel, input logic [1:0] z);
    int s, n, b;
    logic [31:0] r;
    s = mset(sel);
    n = (z == 2'd0) ? 1 : ((z == 2'd1) ? 2 : 4);
    b = (int'(sel[3:0]) / n) * n;
    r = 32'd0;
    for (int k = 0; k < n; k++) r[8*k +: 8] = m[s][b+k];
    return r;
  endfunction

  function automatic logic [31:0] mstep(input logic [1:0] z);
    return (z == 2'd2) ? 32'd4 : ((z == 2'd1) ? 32'd2 : 32'd1);
  endfunction

  task automatic mapply();
    int ps, pb, ws, wb, n;
    logic [31:0] pv;
    if (rst) begin
      for (int s = 0; s <= NB; s++)
        for (int b = 0; b < 16; b++) m[s][b] = 8'd0;
      for (int k = 0; k < 4; k++) m[NB][12+k] = XSP[8*k +: 8];
      mrfp = 0;
    end else if (bus.cen) begin
      ps = mset(bus.rd0_sel);
      pb = (int'(bus.rd0_sel[3:0]) / 4) * 4;
      ws = mset(bus.wr_sel);
      if (bus.ptr_dec || bus.ptr_inc) begin
        pv = bus.ptr_dec ? mread(bus.rd0_sel, 2'd2) - mstep(bus.step_z)
                         : mread(bus.rd0_sel, 2'd2) + mstep(bus.step_z);
        for (int k = 0; k < 4; k++) m[ps][pb+k] = pv[8*k +: 8];
      end
      if (bus.wr_en) begin
        n  = (bus.wr_z == 2'd0) ? 1 : ((bus.wr_z == 2'd1) ? 2 : 4);
        wb = (int'(bus.wr_sel[3:0]) / n) * n;
        for (int k = 0; k < n; k++) m[ws][wb+k] = bus.wr_data[8*k +: 8];
      end
      if (bus.rf_ld)       mrfp = int'(bus.rf_din) % NB;
      else if (bus.rf_inc) mrfp = (mrfp + 1) % NB;
      else if (bus.rf_dec) mrfp = (mrfp + NB - 1) % NB;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [31:0] ea;
    ea = mread(bus.rd0_sel, 2'd2);
    if (bus.ptr_dec) ea = ea - mstep(bus.step_z);
    check({tag, "_rd0"},  bus.rd0_out, mread(bus.rd0_sel, bus.rd_z));
    check({tag, "_rd1"},  bus.rd1_out, mread(bus.rd1_sel, bus.rd_z));
    check({tag, "_addr"}, bus.addr_out, ea);
    check({tag, "_rfp"},  {29'd0, bus.rfp}, 32'(mrfp));
  endtask

  task automatic idle();
    bus.cen = 1'b1; bus.rd0_sel = 8'h00; bus.rd1_sel = 8'h00; bus.rd_z = 2'd2;
    bus.step_z = 2'd0; bus.ptr_inc = 1'b0; bus.ptr_dec = 1'b0;
    bus.wr_sel = 8'h00; bus.wr_z = 2'd0; bus.wr_en = 1'b0; bus.wr_data = 32'd0;
    bus.rf_inc = 1'b0; bus.rf_dec = 1'b0; bus.rf_ld = 1'b0; bus.rf_din = 3'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    mapply();
    #1;
  endtask

  task automatic look(input logic [7:0] sel, input logic [1:0] z);
    bus.rd0_sel = sel;
    bus.rd_z    = z;
    #1;
  endtask

  task automatic wr(input logic [7:0] sel, input logic [1:0] z, input logic [31:0] d);
    bus.wr_sel = sel; bus.wr_z = z; bus.wr_data = d; bus.wr_en = 1'b1;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic set_rfp(input logic [2:0] v);
    bus.rf_ld = 1'b1; bus.rf_din = v;
    tick();
    bus.rf_ld = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;

    // Reset state
    look(8'hFC, 2'd2);
    check("rst_xsp", bus.rd0_out, 32'h0000_0100);
    check("rst_addr", bus.addr_out, 32'h0000_0100);
    bus.rd1_sel = 8'h14; #1;
    check("rst_bank", bus.rd1_out, 32'd0);
    check("rst_rfp", {29'd0, bus.rfp}, 32'd0);

    // rfp arithmetic and priority
    bus.rf_inc = 1'b1; repeat (5) tick(); bus.rf_inc = 1'b0;
    check("rfp_inc5", {29'd0, bus.rfp}, 32'd1);
    bus.rf_dec = 1'b1; tick(); tick(); bus.rf_dec = 1'b0;
    check("rfp_dec_wrap", {29'd0, bus.rfp}, 32'd3);
    bus.rf_ld = 1'b1; bus.rf_inc = 1'b1; bus.rf_din = 3'd2; tick(); idle();
    check("rfp_ld_prio", {29'd0, bus.rfp}, 32'd2);

    // Banked access through 0xE / 0xD aliases
    set_rfp(3'd1);
    wr(8'hE4, 2'd2, 32'h1122_3344);
    look(8'h14, 2'd2);
    check("bank1_long", bus.rd0_out, 32'h1122_3344);
    set_rfp(3'd2);
    bus.rd1_sel = 8'hD4; #1;
    check("prev_bank", bus.rd1_out, 32'h1122_3344);
    set_rfp(3'd1);
    wr(8'hE6, 2'd0, 32'h0000_00AA);
    look(8'h14, 2'd2);
    check("byte_merge", bus.rd0_out, 32'h11AA_3344);
    look(8'h16, 2'd0);
    check("byte_read", bus.rd0_out, 32'h0000_00AA);
    look(8'h17, 2'd1);
    check("word_read", bus.rd0_out, 32'h0000_11AA);

    // Pointer pre-decrement / post-increment
    wr(8'hF0, 2'd2, 32'h0000_1000);
    look(8'hF0, 2'd2);
    bus.ptr_dec = 1'b1; bus.step_z = 2'd2; #1;
    check("predec_addr", bus.addr_out, 32'h0000_0FFC);
    tick(); idle();
    look(8'hF0, 2'd2);
    check("predec_reg", bus.rd0_out, 32'h0000_0FFC);
    wr(8'hF0, 2'd2, 32'hFFFF_FFFF);
    look(8'hF0, 2'd2);
    bus.ptr_inc = 1'b1; bus.step_z = 2'd1;
    tick(); idle();
    look(8'hF0, 2'd2);
    check("postinc_wrap", bus.rd0_out, 32'h0000_0001);

    // Same-edge pointer update and byte write
    wr(8'hF8, 2'd2, 32'h0000_2000);
    look(8'hF8, 2'd2);
    bus.ptr_inc = 1'b1; bus.step_z = 2'd2;
    bus.wr_sel = 8'hF8; bus.wr_z = 2'd0; bus.wr_data = 32'h0000_0055; bus.wr_en = 1'b1;
    tick(); idle();
    look(8'hF8, 2'd2);
    check("ptr_wr_merge", bus.rd0_out, 32'h0000_2055);

    // cen low freezes state but outputs stay live
    bus.cen = 1'b0; bus.ptr_dec = 1'b1; bus.step_z = 2'd2; bus.rf_inc = 1'b1;
    bus.wr_sel = 8'hF8; bus.wr_z = 2'd2; bus.wr_data = 32'hDEAD_BEEF; bus.wr_en = 1'b1;
    #1;
    check("cen0_addr_live", bus.addr_out, 32'h0000_2051);
    tick();
    check("cen0_hold", bus.rd0_out, 32'h0000_2055);
    check("cen0_rfp", {29'd0, bus.rfp}, 32'd1);
    idle();

    // Reset in the middle of activity
    rst = 1'b1;
    bus.wr_sel = 8'hF8; bus.wr_z = 2'd2; bus.wr_data = 32'h1234_5678; bus.wr_en = 1'b1;
    bus.rf_inc = 1'b1; bus.rd0_sel = 8'hFC; bus.ptr_inc = 1'b1;
    tick();
    rst = 1'b0; idle();
    look(8'hFC, 2'd2);
    check("mrst_xsp", bus.rd0_out, 32'h0000_0100);
    look(8'hF8, 2'd2);
    check("mrst_ptr", bus.rd0_out, 32'd0);
    look(8'h14, 2'd2);
    check("mrst_bank", bus.rd0_out, 32'd0);
    check("mrst_rfp", {29'd0, bus.rfp}, 32'd0);

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 31) == 0);
      bus.cen     = ($urandom_range(0, 7) != 0);
      bus.rd0_sel = 8'($urandom_range(0, 255));
      bus.rd1_sel = 8'($urandom_range(0, 255));
      bus.rd_z    = 2'($urandom_range(0, 2));
      bus.step_z  = 2'($urandom_range(0, 3));
      bus.ptr_inc = ($urandom_range(0, 3) == 0);
      bus.ptr_dec = ($urandom_range(0, 3) == 0);
      bus.wr_sel  = ($urandom_range(0, 1) == 0) ? bus.rd0_sel : 8'($urandom_range(0, 255));
      bus.wr_z    = 2'($urandom_range(0, 2));
      bus.wr_en   = ($urandom_range(0, 1) == 0);
      bus.wr_data = $urandom;
      bus.rf_inc  = ($urandom_range(0, 5) == 0);
      bus.rf_dec  = ($urandom_range(0, 5) == 0);
      bus.rf_ld   = ($urandom_range(0, 7) == 0);
      bus.rf_din  = 3'($urandom_range(0, 7));
      #1;
      check_model("rnd");
      tick();
    end
    rst = 1'b0;
    idle();
    #1;
    check_model("final");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
